// File: rtl/lfsr_pkg.sv
// Shared types and constants for the time-multiplexed LFSR scheduler.
// Also holds the round-robin picker used by the scheduler.
package lfsr_pkg;

    localparam int LFSR_N = 8;
    localparam logic [LFSR_N-1:0] DEFAULT_TAPS = 8'b0000_0011;
    localparam logic [LFSR_N-1:0] DEFAULT_SEED = 8'b0000_0001;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SKIP,
        COLLECT,
        PRESENT
    } sched_state_e;

    typedef struct packed {
        logic [LFSR_N-1:0] taps;
        logic [LFSR_N-1:0] state;
    } ctx_t;

    // First set bit at or after ptr, wrapping. The scan runs downward so the
    // last hit, which wins, is the one closest to ptr.
    function automatic int rr_pick(input logic [31:0] req, input int ptr, input int num);
        int idx;
        rr_pick = 0;
        for (int i = num - 1; i >= 0; i--) begin
            idx = ptr + i;
            if (idx >= num) idx = idx - num;
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/lfsr.sv
// Fibonacci LFSR: emits state[0] each valid cycle and shifts right, feeding
// the XOR of tapped bits into the MSB. A load costs one invalid cycle.
module lfsr #(
    parameter int          N               = 8,
    parameter bit          VARIABLE_CONFIG = 1'b1,
    parameter logic [N-1:0] TAPS           = '0
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         load_config_i,
    input  logic [N-1:0] taps_i,
    input  logic [N-1:0] start_value_i,
    output logic         data_o,
    output logic         valid_o
);

    logic [N-1:0] r_state;
    logic [N-1:0] r_taps;
    logic         r_valid;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state <= '0;
            r_taps  <= TAPS;
            r_valid <= 1'b0;
        end else if (load_config_i) begin
            r_state <= start_value_i;
            r_taps  <= VARIABLE_CONFIG ? taps_i : TAPS;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b1;
            // Only advance once the current bit has been presented as valid.
            if (r_valid) r_state <= {^(r_state & r_taps), r_state[N-1:1]};
        end
    end

    assign data_o  = r_state[0];
    assign valid_o = r_valid;

endmodule

// File: rtl/lfsr_stream_sched.sv
// Shares one LFSR between NUM_REQ requesters, each with its own taps/state
// context; words go out on a valid/ready port tagged with the owner id.
module lfsr_stream_sched
    import lfsr_pkg::*;
#(
    parameter int          N            = LFSR_N,
    parameter int          W            = 8,
    parameter int          NUM_REQ      = 4,
    parameter logic [N-1:0] DEFAULT_TAPS = lfsr_pkg::DEFAULT_TAPS,
    parameter logic [N-1:0] DEFAULT_SEED = lfsr_pkg::DEFAULT_SEED,
    localparam int         IDW          = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               cfg_we_i,
    input  logic [IDW-1:0]     cfg_id_i,
    input  logic [N-1:0]       cfg_taps_i,
    input  logic [N-1:0]       cfg_seed_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [W-1:0]       out_data_o,
    output logic [IDW-1:0]     out_id_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(W + N + 1);

    sched_state_e     r_state, w_next;
    logic [IDW-1:0]   r_rr_ptr, r_grant, r_id, w_pick;
    logic [CNT_W-1:0] r_cnt;
    logic [W+N-1:0]   r_shift, w_full;
    logic [W-1:0]     r_data;
    logic             r_suppress;
    ctx_t             r_ctx [NUM_REQ];
    logic             w_lfsr_bit, w_lfsr_vld, w_load, w_last, w_cfg_hit, w_wb;

    assign w_pick    = IDW'(rr_pick(32'(req_i), int'(r_rr_ptr), NUM_REQ));
    assign w_full    = {w_lfsr_bit, r_shift[W+N-1:1]};
    assign w_last    = (r_state == COLLECT) && w_lfsr_vld && (r_cnt == CNT_W'(W + N - 1));
    assign w_cfg_hit = cfg_we_i && (cfg_id_i == r_grant);
    // A config write to the owner, now or earlier in flight, beats the write-back.
    assign w_wb      = w_last && !r_suppress && !w_cfg_hit;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) r_state <= IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|req_i) w_next = LOAD;
            LOAD:    w_next = SKIP;
            SKIP:    w_next = COLLECT;
            COLLECT: if (w_last) w_next = PRESENT;
            PRESENT: if (out_ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (r_state != IDLE);
        out_valid_o = (r_state == PRESENT);
        w_load      = (r_state == LOAD);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_id       <= '0;
            r_suppress <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (|req_i) begin
                    r_grant    <= w_pick;
                    r_rr_ptr   <= (w_pick == IDW'(NUM_REQ - 1)) ? '0 : w_pick + IDW'(1);
                    r_suppress <= 1'b0;
                    r_cnt      <= '0;
                end
                LOAD, SKIP: if (w_cfg_hit) r_suppress <= 1'b1;
                COLLECT: begin
                    if (w_cfg_hit) r_suppress <= 1'b1;
                    if (w_lfsr_vld) begin
                        r_shift <= w_full;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                    if (w_last) begin
                        r_data <= w_full[W-1:0];
                        r_id   <= r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < NUM_REQ; k++) r_ctx[k] <= '{taps: DEFAULT_TAPS, state: DEFAULT_SEED};
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (cfg_we_i && cfg_id_i == IDW'(k))
                    r_ctx[k] <= '{taps: cfg_taps_i, state: cfg_seed_i};
                else if (w_wb && r_grant == IDW'(k))
                    r_ctx[k].state <= w_full[W+N-1:W];
            end
        end
    end

    assign out_data_o = r_data;
    assign out_id_o   = r_id;

    lfsr #(
        .N              (N),
        .VARIABLE_CONFIG(1'b1),
        .TAPS           (DEFAULT_TAPS)
    ) u_lfsr (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .load_config_i(w_load),
        .taps_i       (r_ctx[r_grant].taps),
        .start_value_i(r_ctx[r_grant].state),
        .data_o       (w_lfsr_bit),
        .valid_o      (w_lfsr_vld)
    );

endmodule

// File: tb/tb_lfsr_stream_sched.sv
// Scoreboard bench: grants are predicted from a sequence-level model of each
// requester's LFSR stream; a negedge monitor checks every presented word.
module tb_lfsr_stream_sched;

    localparam int N   = 8;
    localparam int W   = 8;
    localparam int NR  = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  req_i;
    logic           cfg_we_i;
    logic [IDW-1:0] cfg_id_i;
    logic [N-1:0]   cfg_taps_i, cfg_seed_i;
    logic           out_valid_o, out_ready_i, busy_o;
    logic [W-1:0]   out_data_o;
    logic [IDW-1:0] out_id_o;

    always #5 clk = ~clk;

    lfsr_stream_sched #(.N(N), .W(W), .NUM_REQ(NR)) dut (
        .clk_i(clk), .reset_ni(rst_n), .req_i(req_i),
        .cfg_we_i(cfg_we_i), .cfg_id_i(cfg_id_i), .cfg_taps_i(cfg_taps_i), .cfg_seed_i(cfg_seed_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_id_o(out_id_o), .busy_o(busy_o)
    );

    typedef struct { int id; logic [W-1:0] data; } exp_t;
    exp_t         q[$];
    logic [N-1:0] m_taps[NR];
    logic [N-1:0] m_st[NR];
    int           m_ptr;
    int           n_cmp = 0, n_err = 0, n_pop = 0;
    bit           mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NR; k++) begin
            m_taps[k] = 8'h03;
            m_st[k]   = 8'h01;
        end
        m_ptr = 0;
        q.delete();
    endfunction

    // Sequence view: b[0..N-1] is the state, b[n+N] = XOR of taps[j] & b[n+j].
    function automatic void gen(input logic [N-1:0] taps, input logic [N-1:0] st,
                                output logic [W-1:0] word, output logic [N-1:0] nst);
        bit b[W+N];
        bit x;
        for (int i = 0; i < N; i++) b[i] = st[i];
        for (int n = 0; n < W; n++) begin
            x = 1'b0;
            for (int j = 0; j < N; j++) x ^= taps[j] & b[n+j];
            b[n+N] = x;
        end
        for (int i = 0; i < W; i++) word[i] = b[i];
        for (int i = 0; i < N; i++) nst[i] = b[W+i];
    endfunction

    function automatic void grant(input logic [NR-1:0] req);
        int g;
        logic [W-1:0] w;
        logic [N-1:0] ns;
        g = -1;
        for (int i = 0; i < NR; i++)
            if (g < 0 && req[(m_ptr + i) % NR]) g = (m_ptr + i) % NR;
        gen(m_taps[g], m_st[g], w, ns);
        m_st[g] = ns;
        q.push_back('{g, w});
        m_ptr = (g + 1) % NR;
    endfunction

    task automatic drive(input logic [NR-1:0] req, input bit ready, input bit we = 1'b0,
                         input int id = 0, input logic [N-1:0] taps = '0, input logic [N-1:0] seed = '0);
        @(posedge clk);
        #1;
        req_i = req; out_ready_i = ready; cfg_we_i = we;
        cfg_id_i = IDW'(id); cfg_taps_i = taps; cfg_seed_i = seed;
        if (we) begin
            m_taps[id] = taps;
            m_st[id]   = seed;
        end
        if (rst_n && !busy_o && req != '0) grant(req);
    endtask

    task automatic run_until(input int target, input logic [NR-1:0] req, input int budget);
        int c = 0;
        while (n_pop < target && c < budget) begin
            drive(req, 1'b1);
            c++;
        end
        if (n_pop < target) fail("run_until");
    endtask

    task automatic drain();
        int c = 0;
        while ((q.size() != 0 || busy_o) && c < 300) begin
            drive('0, 1'b1);
            c++;
        end
        if (q.size() != 0 || busy_o) fail("drain");
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst_n = 1'b0; req_i = '0; cfg_we_i = 1'b0; out_ready_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && out_valid_o) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got id %0d data %0h, expected none", out_id_o, out_data_o);
                end else begin
                    chk("word_id", 32'(out_id_o), 32'(q[0].id));
                    chk("word_data", 32'(out_data_o), 32'(q[0].data));
                    if (out_ready_i) begin
                        void'(q.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        rst_n = 1'b0; req_i = '0; cfg_we_i = 1'b0; cfg_id_i = '0;
        cfg_taps_i = '0; cfg_seed_i = '0; out_ready_i = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_data", 32'(out_data_o), 0);
        chk("rst_id", 32'(out_id_o), 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Single requester from defaults, with first-word latency.
        drive(4'b0001, 1'b1);
        lat = -1;
        for (int c = 1; c < 60; c++) begin
            drive(4'b0001, 1'b1);
            if (out_valid_o) begin
                lat = c;
                break;
            end
        end
        chk("latency", 32'(lat), 19);
        run_until(n_pop + 3, 4'b0001, 120);
        drain();

        // Two interleaved default streams.
        reset_dut();
        run_until(n_pop + 4, 4'b0011, 160);
        drain();

        // Backpressure during the first PRESENT.
        reset_dut();
        drive(4'b0001, 1'b1);
        for (int c = 0; c < 60 && !out_valid_o; c++) drive(4'b0001, 1'b1);
        repeat (20) drive(4'b0001, 1'b0);
        run_until(n_pop + 3, 4'b0001, 120);
        drain();

        // Config write, then a config write to the in-flight owner.
        drive('0, 1'b1, 1'b1, 2, 8'h03, 8'hA5);
        run_until(n_pop + 1, 4'b0100, 60);
        drain();
        drive(4'b0001, 1'b1);
        repeat (5) drive('0, 1'b1);
        drive('0, 1'b1, 1'b1, 0, 8'h1D, 8'h5A);
        drain();
        run_until(n_pop + 1, 4'b0001, 60);
        drain();

        // All requesters held: round-robin fairness.
        run_until(n_pop + 5, 4'b1111, 200);
        drain();

        // Random mix of requests, backpressure and config writes.
        repeat (400) begin
            drive(NR'($urandom), ($urandom % 4) != 0, ($urandom % 16) == 0,
                  int'($urandom % NR), N'($urandom), N'($urandom));
        end
        drain();

        // Asynchronous reset mid-COLLECT with a stale word still on the outputs.
        reset_dut();
        drive(4'b0010, 1'b1);
        drain();
        drive(4'b0001, 1'b1);
        repeat (8) drive('0, 1'b1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", 32'(out_valid_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_data", 32'(out_data_o), 0);
        chk("arst_id", 32'(out_id_o), 0);
        #1;
        rst_n = 1'b1;
        run_until(n_pop + 1, 4'b0001, 60);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
